// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: priority one-hot encoder behind a 2-entry output FIFO.
// Optional macro ONEHOT_ENC_ERRCNT_EN enables the saturating non-one-hot counter.
module onehot_encoder_stream #(
    parameter int WIDTH    = 8,
    parameter int CW       = $clog2(WIDTH),
    parameter bit MSB_PRIO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_code,
    output logic             out_onehot,
    output logic             out_zero,
    input  logic             err_clr,
    output logic [15:0]      err_count
);

    typedef struct packed {
        logic [CW-1:0] code;
        logic          onehot;
        logic          zero;
    } ent_t;

    logic [CW-1:0]    enc_code;
    logic [WIDTH-1:0] data_m1;
    logic             enc_zero;
    logic             enc_onehot;
    ent_t             enc;

    ent_t       mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    ent_t       head;

    // Later matches overwrite earlier ones, so scan order sets priority.
    always_comb begin
        enc_code = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_PRIO) begin
                if (in_data[i]) enc_code = CW'(i);
            end else begin
                if (in_data[WIDTH-1-i]) enc_code = CW'(WIDTH-1-i);
            end
        end
    end

    assign data_m1    = in_data - WIDTH'(1);
    assign enc_zero   = ~|in_data;
    assign enc_onehot = !enc_zero && ((in_data & data_m1) == '0);

    always_comb begin
        enc        = '0;
        enc.code   = enc_code;
        enc.onehot = enc_onehot;
        enc.zero   = enc_zero;
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload is forced to zero whenever the buffer is empty.
    assign head       = mem[rd_ptr];
    assign out_code   = out_valid ? head.code : '0;
    assign out_onehot = out_valid && head.onehot;
    assign out_zero   = out_valid && head.zero;

`ifdef ONEHOT_ENC_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 16'd0;
        end else if (err_clr) begin
            err_q <= 16'd0;
        end else if (push && !enc_onehot && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_count      = 16'd0;
`endif

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream: randomized + directed bench against a queue model.
// Four DUT configs share handshakes: 8/MSB, 8/LSB, 64/MSB, 2/MSB.
module tb_onehot_encoder_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        err_clr;
    logic [7:0]  d8;
    logic [63:0] d64;
    logic [1:0]  d2;

    logic [3:0]  ir, ov, oh, oz;
    logic [2:0]  oc_a, oc_b;
    logic [5:0]  oc_c;
    logic        oc_d;
    logic [15:0] ec_a, ec_b, ec_c, ec_d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        bit oh;
        bit z;
    } ent_t;

    ent_t q [4][$];
    int   errm [4];
    bit   msb [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    onehot_encoder_stream #(.WIDTH(8), .MSB_PRIO(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(d8), .out_valid(ov[0]), .out_ready(out_ready),
        .out_code(oc_a), .out_onehot(oh[0]), .out_zero(oz[0]),
        .err_clr(err_clr), .err_count(ec_a)
    );

    onehot_encoder_stream #(.WIDTH(8), .MSB_PRIO(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(d8), .out_valid(ov[1]), .out_ready(out_ready),
        .out_code(oc_b), .out_onehot(oh[1]), .out_zero(oz[1]),
        .err_clr(err_clr), .err_count(ec_b)
    );

    onehot_encoder_stream #(.WIDTH(64), .MSB_PRIO(1'b1)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(d64), .out_valid(ov[2]), .out_ready(out_ready),
        .out_code(oc_c), .out_onehot(oh[2]), .out_zero(oz[2]),
        .err_clr(err_clr), .err_count(ec_c)
    );

    onehot_encoder_stream #(.WIDTH(2), .MSB_PRIO(1'b1)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
        .in_data(d2), .out_valid(ov[3]), .out_ready(out_ready),
        .out_code(oc_d), .out_onehot(oh[3]), .out_zero(oz[3]),
        .err_clr(err_clr), .err_count(ec_d)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] din(input int k);
        case (k)
            0, 1:    din = {56'd0, d8};
            2:       din = d64;
            default: din = {62'd0, d2};
        endcase
    endfunction

    function automatic logic [63:0] code_of(input int k);
        case (k)
            0:       code_of = {61'd0, oc_a};
            1:       code_of = {61'd0, oc_b};
            2:       code_of = {58'd0, oc_c};
            default: code_of = {63'd0, oc_d};
        endcase
    endfunction

    function automatic logic [63:0] err_of(input int k);
        case (k)
            0:       err_of = {48'd0, ec_a};
            1:       err_of = {48'd0, ec_b};
            2:       err_of = {48'd0, ec_c};
            default: err_of = {48'd0, ec_d};
        endcase
    endfunction

    // Reference: highest/lowest set index found by shifting the value.
    function automatic ent_t ref_enc(input logic [63:0] d, input bit hi);
        ent_t        e;
        logic [63:0] t;
        e.code = 0;
        e.z    = (d == 64'd0);
        e.oh   = ($countones(d) == 1);
        t      = d;
        if (!e.z) begin
            if (hi) begin
                while (t > 64'd1) begin
                    t = t >> 1;
                    e.code++;
                end
            end else begin
                while (!t[0]) begin
                    t = t >> 1;
                    e.code++;
                end
            end
        end
        return e;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("valid%0d", k), ov[k], q[k].size() > 0);
            if (q[k].size() > 0) begin
                check($sformatf("code%0d", k), code_of(k), q[k][0].code);
                check($sformatf("onehot%0d", k), oh[k], q[k][0].oh);
                check($sformatf("zero%0d", k), oz[k], q[k][0].z);
            end
            check($sformatf("err%0d", k), err_of(k), errm[k]);
        end
    endtask

    task automatic step();
        bit   acc [4];
        ent_t e;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ready%0d", k), ir[k], q[k].size() < 2);
            acc[k] = in_valid && (q[k].size() < 2);
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            e = ref_enc(din(k), msb[k]);
            if (q[k].size() > 0 && out_ready) void'(q[k].pop_front());
            if (acc[k]) q[k].push_back(e);
`ifdef ONEHOT_ENC_ERRCNT_EN
            if (err_clr) errm[k] = 0;
            else if (acc[k] && !e.oh && errm[k] < 65535) errm[k]++;
`endif
        end
        #1;
        check_outputs();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_valid%0d", k), ov[k], 1'b0);
            check($sformatf("rst_code%0d", k), code_of(k), 64'd0);
            check($sformatf("rst_oh%0d", k), oh[k], 1'b0);
            check($sformatf("rst_zero%0d", k), oz[k], 1'b0);
            check($sformatf("rst_err%0d", k), err_of(k), 64'd0);
            q[k].delete();
            errm[k] = 0;
        end
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        err_clr = 1'b0;
        d8 = '0;
        d64 = '0;
        d2 = '0;
        for (int k = 0; k < 4; k++) errm[k] = 0;
        reset_pulse();
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d8 = 8'd1 << i;
            d64 = 64'd1 << (i * 9);
            d2 = 2'd1 << (i % 2);
            step();
            check("sweep_code", code_of(0), i);
            check("sweep_oh", oh[0], 1'b1);
        end

        d8 = 8'h05;
        d64 = 64'd1 << 63;
        d2 = 2'b11;
        step();
        check("prio_msb", code_of(0), 64'd2);
        check("prio_lsb", code_of(1), 64'd0);
        check("prio_oh", oh[0], 1'b0);
        check("w64_bit63", code_of(2), 64'd63);
        check("w2_multi", code_of(3), 64'd1);

        d8 = 8'h00;
        d64 = 64'd0;
        d2 = 2'b00;
        step();
        check("zero_flag", oz[0], 1'b1);
        check("zero_code", code_of(0), 64'd0);

        out_ready = 1'b0;
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            d8 = 8'h01 << i;
            d64 = 64'h1 << (20 + i);
            d2 = 2'b01;
            step();
        end
        check("bp_full", ir[0], 1'b0);
        out_ready = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        repeat (2) step();

        out_ready = 1'b0;
        in_valid = 1'b1;
        d8 = 8'h10;
        repeat (2) step();
        reset_pulse();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       d8 = 8'd0;
                1, 2:    d8 = 8'd1 << $urandom_range(0, 7);
                default: d8 = 8'($urandom);
            endcase
            if ($urandom_range(0, 1) == 0) d64 = 64'd1 << $urandom_range(0, 63);
            else d64 = {$urandom, $urandom};
            d2 = 2'($urandom_range(0, 3));
            step();
        end
        err_clr = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();

`ifdef ONEHOT_ENC_ERRCNT_EN
        reset_pulse();
        in_valid = 1'b1;
        out_ready = 1'b1;
        d8 = 8'd0;
        d64 = 64'd0;
        d2 = 2'd0;
        repeat (65535) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            errm[k] = 65535;
            q[k].delete();
            q[k].push_back('{0, 1'b0, 1'b1});
        end
        check_outputs();
        step();
        check("sat_hold", err_of(0), 64'hFFFF);
        err_clr = 1'b1;
        step();
        check("clr_wins", err_of(0), 64'd0);
        err_clr = 1'b0;
        in_valid = 1'b0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_stream.md
ONEHOT_ENCODER_STREAM -- requirements
Module: onehot_encoder_stream

Interface
REQ-001 Parameter WIDTH, default 8, number of input request lines, legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH), code width, derived and never overridden.
REQ-003 Parameter MSB_PRIO, default 1: 1 = highest set index wins, 0 = lowest set index wins.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_data  input  WIDTH  request vector; expected one-hot.
REQ-009 out_valid  output  1  head entry of the output buffer valid.
REQ-010 out_ready  input  1  downstream accepts the head entry.
REQ-011 out_code  output  CW  encoded index of the head entry.
REQ-012 out_onehot  output  1  head entry's in_data had exactly one bit set.
REQ-013 out_zero  output  1  head entry's in_data was all zeros.
REQ-014 err_clr  input  1  synchronous clear of err_count.
REQ-015 err_count  output  16  saturating count of accepted non-one-hot beats.

Function
REQ-016 Accept: a beat is accepted on a rising edge where in_valid && in_ready.
REQ-017 Encode: code = index of the winning set bit per MSB_PRIO; all-zero data gives code 0, out_zero=1, out_onehot=0.
REQ-018 Multi-hot data gives the priority-resolved code, out_onehot=0, out_zero=0; output is never X.
REQ-019 Buffer: 2-entry FIFO of {code, onehot, zero}; in_ready = (occupancy < 2), combinational on occupancy only.
REQ-020 Latency: a beat accepted into an empty buffer appears on out_valid/out_code on the next cycle.
REQ-021 Pop: the head leaves on a rising edge where out_valid && out_ready.
REQ-022 Simultaneous push and pop at occupancy 1: occupancy stays 1; the new entry becomes head on the following cycle.
REQ-023 At occupancy 2, in_ready=0 and no beat is accepted, even if out_ready=1 in the same cycle.
REQ-024 Order is strictly FIFO; no entry is dropped or duplicated.
REQ-025 out_code/out_onehot/out_zero hold stable while out_valid=1 && out_ready=0.
REQ-026 err_count increments by 1 on each accepted beat with onehot=0 and saturates at 16'hFFFF.
REQ-027 err_clr and an increment in the same cycle give err_count=0 (clear wins).

Reset
REQ-028 rst asserted forces immediately, with no clock: occupancy 0, out_valid=0, out_code=0, out_onehot=0, out_zero=0, err_count=0; in_ready=1 once reset deasserts.
REQ-029 Reset mid-transfer discards all buffered entries; no beat is presented after reset deasserts without a new accept.

Configuration
REQ-030 Macro ONEHOT_ENC_ERRCNT_EN defined: err_count per REQ-026 and REQ-027.
REQ-031 Macro ONEHOT_ENC_ERRCNT_EN undefined: err_count tied to 0 and err_clr ignored; ports remain; all other behaviour identical.

Verification
REQ-032 Sweep, WIDTH=8, out_ready=1: in_data 8'h01..8'h80 one per cycle -> out_code 0..7 one cycle later, out_onehot=1 on every beat.
REQ-033 Priority, WIDTH=8: in_data 8'h05 -> out_code 2 with MSB_PRIO=1 and 0 with MSB_PRIO=0; out_onehot=0; err_count 1 with the macro defined.
REQ-034 Zero input: in_data 8'h00 accepted -> out_code 0, out_zero=1, out_onehot=0, err_count +1.
REQ-035 Backpressure: out_ready=0, offer 3 beats -> first 2 accepted, in_ready=0 on the third; raise out_ready -> 2 entries drain in order, then the third is accepted.
REQ-036 Reset and saturation: assert rst with 2 entries buffered -> out_valid=0 immediately, nothing presented afterwards; preload err_count to 16'hFFFF, send one error beat -> count stays 16'hFFFF; err_clr on the same edge -> 0.
REQ-037 Parametric: WIDTH=64, in_data bit 63 only -> out_code 63 (CW=6); WIDTH=2 also exercised.
